// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch stage's control, instruction-memory and
//                IF/ID pipeline-register signals.
//                master = fetch stage side, slave = surrounding pipeline/memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
);
  logic              stall_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [WIDTH-1:0]  instr_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              if_id_valid_o;
  logic [WIDTH-1:0]  if_id_instr_o;
  logic [ADDR_W-1:0] if_id_pc_o;
  logic [ADDR_W-1:0] if_id_pc4_o;
  logic              halted_o;
  logic [31:0]       fetch_cnt_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, instr_i,
    output imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc4_o, halted_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, instr_i,
    input  imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o,
           if_id_pc4_o, halted_o, fetch_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: PC register, IF/ID pipeline register,
//                stall/redirect handling and a fetched-instruction counter.
//                Optional macro FETCH_HALT_EN: fetching an all-zero word in RUN
//                inserts a bubble and parks the stage in HALT until a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 256,
  parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);
  localparam int              ADDR_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              halt_hit;

  // Zero-word detection only exists when the halt feature is built in
`ifdef FETCH_HALT_EN
  assign halt_hit = (bus.instr_i == '0);
`else
  assign halt_hit = 1'b0;
`endif

  // Next-state: redirect beats everything except reset, then per-state rules
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;
    if (bus.redirect_i) begin
      // Target is forced word-aligned; a redirect also wakes IDLE/HALT
      pc_d    = bus.redirect_pc_i & ALIGN_MASK;
      valid_d = 1'b0;
      instr_d = NOP;
      ifpc_d  = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          instr_d = NOP;
          ifpc_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          if (!bus.stall_i) begin
            if (halt_hit) begin
              valid_d = 1'b0;
              instr_d = NOP;
              ifpc_d  = '0;
              state_d = HALT;
            end else begin
              valid_d = 1'b1;
              instr_d = bus.instr_i;
              ifpc_d  = pc_q;
              pc_d    = pc_q + PC_STEP;
              cnt_d   = cnt_q + 32'd1;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, PC, IF/ID and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ifpc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr_o   = pc_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.if_id_instr_o = instr_q;
  assign bus.if_id_pc_o    = ifpc_q;
  assign bus.if_id_pc4_o   = ifpc_q + PC_STEP;
  assign bus.fetch_cnt_o   = cnt_q;
`ifdef FETCH_HALT_EN
  assign bus.halted_o      = (state_q == HALT);
`else
  assign bus.halted_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a cycle-level
//                reference model of the fetch rules and a word-array memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [64];

  fetch_unit_if #(.WIDTH(32), .ADDR_W(8)) bus ();

  fetch_unit #(.WIDTH(32), .DEPTH(256), .NOP(32'h00000013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory
  assign bus.instr_i = mem[bus.imem_addr_o[7:2]];

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int          m_mode;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_ifpc;
  logic [31:0] m_cnt;

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_instr = NOP; m_ifpc = 0; m_cnt = 0;
    end else if (bus.redirect_i) begin
      m_pc = {bus.redirect_pc_i[7:2], 2'b00};
      m_valid = 0; m_instr = NOP; m_ifpc = 0; m_mode = 1;
    end else if (m_mode == 0) begin
      m_valid = 0; m_instr = NOP; m_ifpc = 0; m_mode = 1;
    end else if (m_mode == 1 && !bus.stall_i) begin
      w = mem[m_pc / 4];
`ifdef FETCH_HALT_EN
      if (w == 0) begin
        m_valid = 0; m_instr = NOP; m_ifpc = 0; m_mode = 2;
      end else begin
        m_valid = 1; m_instr = w; m_ifpc = m_pc; m_pc = m_pc + 8'd4; m_cnt = m_cnt + 1;
      end
`else
      m_valid = 1; m_instr = w; m_ifpc = m_pc; m_pc = m_pc + 8'd4; m_cnt = m_cnt + 1;
`endif
    end
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [7:0] rpc);
    bus.stall_i = s; bus.redirect_i = r; bus.redirect_pc_i = rpc;
  endtask

  task automatic test_reset();
    rst = 1; drive(0, 1, 8'h40);
    tick(); tick();
    checks++; if (bus.imem_addr_o !== 8'd0) begin errors++; $display("FAIL reset_addr got %h want 00", bus.imem_addr_o); end
    checks++; if (bus.if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.if_id_valid_o); end
    checks++; if (bus.if_id_instr_o !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", bus.if_id_instr_o, NOP); end
    checks++; if ({bus.if_id_pc_o, bus.if_id_pc4_o} !== {8'd0, 8'd4}) begin errors++; $display("FAIL reset_pc got %h/%h want 00/04", bus.if_id_pc_o, bus.if_id_pc4_o); end
    checks++; if ({bus.halted_o, bus.fetch_cnt_o} !== 33'd0) begin errors++; $display("FAIL reset_halt_cnt got %b/%0d want 0/0", bus.halted_o, bus.fetch_cnt_o); end
  endtask

  task automatic test_program();
    mem[0] = 32'h00200613; mem[1] = 32'h00300693; mem[2] = 32'h00e00913;
    drive(0, 0, 0);
    rst = 0;
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_instr_o, bus.imem_addr_o} !== {1'b0, NOP, 8'd0}) begin
      errors++; $display("FAIL idle_bubble got v%b %h addr %h want v0 %h addr 00", bus.if_id_valid_o, bus.if_id_instr_o, bus.imem_addr_o, NOP); end
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o} !== {1'b1, 32'h00200613, 8'd0}) begin
      errors++; $display("FAIL fetch0 got v%b %h pc %h want v1 00200613 pc 00", bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o); end
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o} !== {1'b1, 32'h00300693, 8'd4, 8'd8}) begin
      errors++; $display("FAIL fetch1 got v%b %h pc %h pc4 %h want v1 00300693 pc 04 pc4 08", bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o); end
    checks++; if ({bus.fetch_cnt_o, bus.imem_addr_o} !== {32'd2, 8'd8}) begin
      errors++; $display("FAIL fetch_cnt got %0d addr %h want 2 addr 08", bus.fetch_cnt_o, bus.imem_addr_o); end
  endtask

  task automatic test_stall();
    drive(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({bus.imem_addr_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.fetch_cnt_o} !== {8'd8, 32'h00300693, 8'd4, 32'd2}) begin
        errors++; $display("FAIL stall_hold%0d got addr %h %h pc %h cnt %0d want 08 00300693 04 2", i, bus.imem_addr_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.fetch_cnt_o); end
    end
  endtask

  task automatic test_redirect_priority();
    drive(0, 1, 8'h40);
    tick();
    checks++; if ({bus.imem_addr_o, bus.if_id_valid_o} !== {8'h40, 1'b0}) begin
      errors++; $display("FAIL redirect_40 got addr %h v%b want 40 v0", bus.imem_addr_o, bus.if_id_valid_o); end
    drive(1, 1, 8'h1E);
    tick();
    checks++; if ({bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.fetch_cnt_o} !== {8'h1C, 1'b0, NOP, 8'd0, 8'd4, m_cnt}) begin
      errors++; $display("FAIL redirect_over_stall got addr %h v%b %h pc %h pc4 %h cnt %0d want 1c v0 %h 00 04 %0d", bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.fetch_cnt_o, NOP, m_cnt); end
    drive(0, 0, 0);
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_instr_o} !== {1'b1, 8'h1C, mem[7]}) begin
      errors++; $display("FAIL after_redirect got v%b pc %h %h want v1 1c %h", bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_instr_o, mem[7]); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 8'd252);
    tick();
    drive(0, 0, 0);
    tick();
    checks++; if ({bus.if_id_pc_o, bus.if_id_pc4_o, bus.imem_addr_o} !== {8'd252, 8'd0, 8'd0}) begin
      errors++; $display("FAIL pc_wrap got pc %h pc4 %h addr %h want fc 00 00", bus.if_id_pc_o, bus.if_id_pc4_o, bus.imem_addr_o); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    mem[17] = 32'h0;
    drive(0, 1, 8'd68);
    tick();
    drive(0, 0, 0);
    c0 = m_cnt;
    tick();
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 2; i++) begin
      checks++; if ({bus.halted_o, bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.fetch_cnt_o} !== {1'b1, 8'd68, 1'b0, NOP, c0}) begin
        errors++; $display("FAIL halt%0d got h%b addr %h v%b %h cnt %0d want h1 44 v0 %h %0d", i, bus.halted_o, bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.fetch_cnt_o, NOP, c0); end
      tick();
    end
    drive(0, 1, 8'd0);
    tick();
    drive(0, 0, 0);
    checks++; if ({bus.halted_o, bus.imem_addr_o} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL halt_exit got h%b addr %h want h0 00", bus.halted_o, bus.imem_addr_o); end
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_pc_o} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL halt_refetch got v%b pc %h want v1 00", bus.if_id_valid_o, bus.if_id_pc_o); end
`else
    checks++; if ({bus.halted_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.imem_addr_o, bus.fetch_cnt_o} !== {1'b0, 1'b1, 32'h0, 8'd68, 8'd72, c0 + 32'd1}) begin
      errors++; $display("FAIL zero_word got h%b v%b %h pc %h addr %h cnt %0d want h0 v1 0 44 48 %0d", bus.halted_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.imem_addr_o, bus.fetch_cnt_o, c0 + 32'd1); end
`endif
  endtask

  task automatic test_reset_midstall();
    drive(1, 0, 0);
    tick();
    rst = 1;
    tick();
    checks++; if ({bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.halted_o, bus.fetch_cnt_o} !== {8'd0, 1'b0, NOP, 8'd0, 8'd4, 1'b0, 32'd0}) begin
      errors++; $display("FAIL rst_midstall got addr %h v%b %h pc %h pc4 %h h%b cnt %0d want reset values", bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.halted_o, bus.fetch_cnt_o); end
    rst = 0; drive(0, 0, 0);
    tick();
    checks++; if ({bus.imem_addr_o, bus.if_id_valid_o} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL rst_idle_again got addr %h v%b want 00 v0", bus.imem_addr_o, bus.if_id_valid_o); end
    tick();
    checks++; if ({bus.if_id_valid_o, bus.if_id_pc_o, bus.fetch_cnt_o} !== {1'b1, 8'd0, 32'd1}) begin
      errors++; $display("FAIL rst_first_fetch got v%b pc %h cnt %0d want v1 00 1", bus.if_id_valid_o, bus.if_id_pc_o, bus.fetch_cnt_o); end
  endtask

  task automatic test_random();
    logic [72:0] got, exp;
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 8'($urandom));
      tick();
      got = {bus.imem_addr_o, bus.if_id_valid_o, bus.if_id_instr_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.halted_o, bus.fetch_cnt_o[14:0]};
      exp = {m_pc, m_valid, m_instr, m_ifpc, m_ifpc + 8'd4, (m_mode == 2), m_cnt[14:0]};
      checks++; if (got !== exp || bus.fetch_cnt_o !== m_cnt) begin
        errors++; $display("FAIL random_cycle%0d got %h cnt %0d want %h cnt %0d", i, got, bus.fetch_cnt_o, exp, m_cnt); end
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h10000013 + 32'(i << 7);
    drive(0, 0, 0);
    test_reset();
    test_program();
    test_stall();
    test_redirect_priority();
    test_wrap();
    test_halt();
    test_reset_midstall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
